// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a req/ack imem port
// and buffers {PC, instr} pairs in a small FIFO feeding IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        CLK,
  input  logic        Resetn,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_o,
  output logic [31:0] Instr_o,
  output logic        Valid_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   pcs_q [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   redir_pc;
  logic          push, pop, flush;
  logic          unused_lsb;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redir_pc   = {Redirect_PC[31:2], 2'b00};
  assign unused_lsb = ^Redirect_PC[1:0];
  assign Valid_o    = (cnt_q != '0);
  assign flush      = Redirect;
  assign pop        = Valid_o && !Stall && !Redirect;
  assign cnt_inc    = pop ? cnt_q : cnt_q + 1'b1;

  assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr = addr_q;
  assign PC_o      = Valid_o ? pcs_q[rptr_q] : pc_q;
  assign Instr_o   = Valid_o ? ins_q[rptr_q] : NOP_INSTR;

  // Fetch FSM: next state, next fetch PC, next request address, push.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (Redirect) pc_d = redir_pc;
        state_d = REQ;
        addr_d  = pc_d;
      end
      REQ: begin
        if (imem_ack && Redirect) begin
          pc_d   = redir_pc;
          addr_d = redir_pc;
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
          if (cnt_inc == CW'(DEPTH)) state_d = HOLD;
          else addr_d = pc_d;
        end else if (Redirect) begin
          pc_d    = redir_pc;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (Redirect) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = REQ;
        end else if (pop) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (Redirect) pc_d = redir_pc;
        if (imem_ack) begin
          addr_d  = pc_d;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; a redirect empties it.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = nxt(wptr_q);
      if (pop)  rptr_d = nxt(rptr_q);
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (!push && pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage: capture the acked address and returned word.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pcs_q[i] <= '0;
        ins_q[i] <= '0;
      end
    end else if (push) begin
      pcs_q[wptr_q] <= addr_q;
      ins_q[wptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed steps plus a random phase checked
// against an instruction-stream model (sequential PCs from last target).
module tb_if_fetch_unit;

  localparam logic [31:0] RST = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        Resetn;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_o;
  logic [31:0] Instr_o;
  logic        Valid_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned mem_lat = 0;
  int unsigned lat_cnt = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] exp_pc = RST;
  logic        wait_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  logic [31:0] h;

  if_fetch_unit dut (
    .CLK        (CLK),
    .Resetn     (Resetn),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .Redirect_PC(Redirect_PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PC_o       (PC_o),
    .Instr_o    (Instr_o),
    .Valid_o    (Valid_o)
  );

  always #5 CLK = ~CLK;

  // Memory: acks after mem_lat waiting cycles; data is a function of address.
  assign imem_ack   = imem_req && !mem_hold && (lat_cnt >= mem_lat);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge CLK) begin
    if (!imem_req || imem_ack) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: model checks on current inputs, then advance to next negedge.
  task automatic tick();
    #1;
    if (Resetn) begin
      if (Valid_o && !Stall && !Redirect) begin
        check("pop_pc", PC_o, exp_pc);
        check("pop_instr", Instr_o, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
      end
      if (!Valid_o) check("empty_nop", Instr_o, NOP);
      if (wait_prev) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_held", imem_addr, addr_prev);
      end
      if (Redirect) exp_pc = {Redirect_PC[31:2], 2'b00};
      wait_prev = imem_req && !imem_ack;
      addr_prev = imem_addr;
    end else begin
      wait_prev = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    Resetn = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    Redirect_PC = '0;
    @(negedge CLK);
    ticks(2);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RST);
    check("rst_valid", {31'd0, Valid_o}, 32'd0);
    check("rst_instr", Instr_o, NOP);
    check("rst_pc", PC_o, RST);

    // Zero-wait memory: valid two edges after release, 1 instr/cycle.
    Resetn = 1'b1;
    exp_pc = RST;
    tick();
    check("boot_valid", {31'd0, Valid_o}, 32'd0);
    check("boot_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("lat_valid", {31'd0, Valid_o}, 32'd1);
    check("lat_pc", PC_o, RST);
    for (int i = 0; i < 6; i++) begin
      check("seq_pc", PC_o, RST + 32'(4 * i));
      tick();
    end

    // Stall until HOLD, then release and resume sequentially.
    h = exp_pc;
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", PC_o, h);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    Stall = 1'b0;
    tick();
    check("resume_addr", imem_addr, h + 32'd8);
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_pc", PC_o, h + 32'd4);

    // Slow memory: FIFO runs empty, addr must hold while waiting.
    mem_lat = 3;
    ticks(20);

    // Redirect with nothing outstanding (from HOLD).
    mem_lat = 0;
    Stall = 1'b1;
    ticks(12);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0100;
    tick();
    Redirect = 1'b0;
    check("flush_valid", {31'd0, Valid_o}, 32'd0);
    check("redir_addr", imem_addr, 32'h0000_0100);
    Stall = 1'b0;
    tick();
    check("redir_valid", {31'd0, Valid_o}, 32'd1);
    check("redir_pc", PC_o, 32'h0000_0100);
    ticks(3);

    // Redirect while a request to 0x8 waits.
    Stall = 1'b1;
    ticks(12);
    mem_hold = 1'b1;
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0008;
    tick();
    Redirect = 1'b0;
    Stall = 1'b0;
    tick();
    check("wait8_addr", imem_addr, 32'h0000_0008);
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0200;
    tick();
    Redirect = 1'b0;
    tick();
    check("drain_addr", imem_addr, 32'h0000_0008);
    check("drain_valid", {31'd0, Valid_o}, 32'd0);
    mem_hold = 1'b0;
    tick();
    check("post_drain", imem_addr, 32'h0000_0200);
    mem_hold = 1'b1;
    tick();
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0240;
    tick();
    Redirect = 1'b0;
    tick();
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0300;
    tick();
    Redirect = 1'b0;
    check("drain2_addr", imem_addr, 32'h0000_0200);
    check("drain2_valid", {31'd0, Valid_o}, 32'd0);
    mem_hold = 1'b0;
    tick();
    check("newest_wins", imem_addr, 32'h0000_0300);
    tick();
    check("d2_valid", {31'd0, Valid_o}, 32'd1);
    check("d2_pc", PC_o, 32'h0000_0300);

    // PC wrap at 2^32, then random traffic against the stream model.
    Redirect = 1'b1;
    Redirect_PC = 32'hFFFF_FFF8;
    tick();
    Redirect = 1'b0;
    ticks(6);
    for (int i = 0; i < 400; i++) begin
      Stall = ($urandom_range(0, 3) == 0);
      Redirect = ($urandom_range(0, 15) == 0);
      Redirect_PC = $urandom;
      mem_lat = $urandom_range(0, 3);
      tick();
    end
    Redirect = 1'b0;
    Stall = 1'b1;
    mem_lat = 0;
    ticks(12);

    // Misaligned target, then reset in the middle of a request.
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0102;
    tick();
    Redirect = 1'b0;
    check("align_addr", imem_addr, 32'h0000_0100);
    mem_hold = 1'b1;
    tick();
    Resetn = 1'b0;
    #1;
    check("rst_drop_req", {31'd0, imem_req}, 32'd0);
    check("rst_mid_addr", imem_addr, RST);
    check("rst_mid_valid", {31'd0, Valid_o}, 32'd0);
    @(negedge CLK);
    ticks(2);
    mem_hold = 1'b0;
    Stall = 1'b0;
    Resetn = 1'b1;
    exp_pc = RST;
    tick();
    check("reboot_req", {31'd0, imem_req}, 32'd1);
    check("reboot_addr", imem_addr, RST);
    tick();
    check("reboot_valid", {31'd0, Valid_o}, 32'd1);
    check("reboot_pc", PC_o, RST);
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues requests on a req/ack instruction-memory port.
- Buffers returned {PC, instruction} pairs in a small FIFO and presents the FIFO head to IF/ID.
- Honours hazard-unit stalls and branch/jump redirects, including redirects that arrive while a memory request is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when no valid entry exists (addi x0,x0,0).
- DEPTH, 2, fetch-buffer entries; legal values 2..8.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- Resetn  input  1  reset, asynchronous, active-low.
- Stall  input  1  1 = IF/ID is holding; do not pop the buffer.
- Redirect  input  1  taken branch/jump; flush and refetch.
- Redirect_PC  input  32  target address; bits [1:0] ignored (treated as 0).
- imem_req  output  1  memory request valid.
- imem_addr  output  32  request address; stable while imem_req=1 and no ack.
- imem_ack  input  1  request complete; imem_rdata valid in the same cycle.
- imem_rdata  input  32  instruction word.
- PC_o  output  32  PC of head entry (to IF/ID PC_i).
- Instr_o  output  32  instruction of head entry (to IF/ID Instr_i).
- Valid_o  output  1  head entry valid.

Behaviour:
- Clock is CLK; reset is Resetn, asynchronous and active-low.
- Reset state: state=BOOT, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, Valid_o=0, Instr_o=NOP_INSTR, PC_o=fetch_pc.
- Asserting Resetn low mid-request drops imem_req immediately; memory must discard the pending transaction.
- Outputs: when the FIFO is non-empty, Valid_o=1 and PC_o/Instr_o show the head entry. When empty, Valid_o=0, Instr_o=NOP_INSTR, PC_o=fetch_pc.
- Pop: at posedge when Valid_o=1, Stall=0 and Redirect=0.
- Push: at posedge on imem_ack in state REQ with Redirect=0; pushes {imem_addr, imem_rdata}, then fetch_pc += 4 (mod 2^32). Push and pop may occur in the same cycle.
- imem_addr is a register, loaded with the next fetch_pc whenever the next state is REQ.
- States and transitions:
  - BOOT: imem_req=0. Go to REQ next cycle.
  - REQ: imem_req=1.
    - ack & Redirect: discard data, flush, fetch_pc<=Redirect_PC, stay REQ.
    - ack & ~Redirect: push; go to HOLD if the post-push count == DEPTH, else stay REQ.
    - ~ack & Redirect: flush, fetch_pc<=Redirect_PC, go to DRAIN; imem_addr keeps the stale address.
    - otherwise: stay; imem_req and imem_addr held.
  - HOLD: imem_req=0.
    - Redirect: flush, fetch_pc<=Redirect_PC, go to REQ.
    - else if pop: go to REQ.
    - else stay.
  - DRAIN: imem_req=1, imem_addr=stale address; returned data is always discarded.
    - ack: go to REQ using fetch_pc, or Redirect_PC if Redirect is asserted the same cycle.
    - Redirect without ack: fetch_pc<=Redirect_PC, stay DRAIN; the newest redirect wins.
- Redirect has priority over Stall and over pop; the flush empties the FIFO in the same edge.
- imem_req is asserted only when count < DEPTH; the FIFO never overflows.
- Pop from an empty FIFO is impossible because Valid_o=0.
- Latency with a zero-wait memory (ack tied to req): reset release at edge 0 gives Valid_o=1, PC_o=RESET_PC after edge 2. Steady throughput is 1 instr/cycle with Stall=0.
- FIFO pointers wrap modulo DEPTH; count is held in a separate register of width clog2(DEPTH+1).

Test Plan:
- Zero-wait memory returning instr = addr ^ 32'hA5A5_0000, Stall=0, release reset -> Valid_o rises two edges later; PC_o sequence 0,4,8,12,... one per cycle; Instr_o matches.
- Stall=1 for 5 cycles, DEPTH=2 -> state HOLD after 2 pushes; imem_req=0; PC_o held at the stalled entry. Stall=0 -> entries drain in order, fetch resumes at the next sequential PC.
- Memory ack delayed 3 cycles -> imem_addr stable for all waiting cycles; Valid_o=0 with Instr_o=32'h0000_0013 while empty.
- Redirect to 32'h0000_0100 with no request outstanding -> FIFO flushed the same edge; next imem_addr=0x100; first valid PC_o=0x100.
- Redirect to 0x200 while a request to 0x8 waits (ack 2 cycles later) -> imem_addr stays 0x8 until ack, data discarded (never Valid_o). Next request is 0x200. A second redirect to 0x300 during DRAIN -> next request is 0x300.
- Redirect_PC=32'h0000_0102, plus Resetn pulsed low mid-request -> fetch address 0x100; reset drops imem_req the same cycle and restarts at RESET_PC via BOOT.
